// File: rtl/riscv_pkg.sv
// Shared definitions for the core front end: fetch FSM encoding and instruction constants.
package riscv_pkg;

    localparam int unsigned INSTR_W     = 32;
    localparam logic [6:0]  HALT_OPCODE = 7'h7F;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch controller: owns the word-addressed PC, issues one request at a
// time to instruction memory, holds the returned word for decode, handles redirects and HALT.
module fetch_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned       WIDTH      = 32,
    parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
    parameter int unsigned       COUNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    output logic                 imem_req,
    output logic [WIDTH-1:0]     imem_addr,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,

    output logic                 ins_valid,
    output logic [INSTR_W-1:0]   ins_data,
    output logic [WIDTH-1:0]     ins_pc,
    input  logic                 ins_ready,

    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_addr,
    input  logic                 resume,

    output logic                 halted,
    output logic [COUNT_W-1:0]   fetch_count
);

    fetch_state_e     state;
    logic [WIDTH-1:0] pc;
    // Set when the outstanding request belongs to a stale PC and its data must be discarded.
    logic             drop;

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            drop        <= 1'b0;
            imem_req    <= 1'b0;
            ins_valid   <= 1'b0;
            halted      <= 1'b0;
            ins_data    <= '0;
            ins_pc      <= '0;
            fetch_count <= '0;
        end else begin
            imem_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    state <= WAIT;
                    if (redirect_valid) begin
                        pc   <= redirect_addr;
                        drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc   <= redirect_addr;
                        drop <= 1'b1;
                    end
                    if (imem_rvalid) begin
                        // A redirect in the same cycle as the data also makes it stale; the
                        // response is consumed here, so nothing is left outstanding to drop.
                        if (drop || redirect_valid) begin
                            drop     <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else if (imem_rdata[6:0] == HALT_OPCODE) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            ins_data  <= imem_rdata;
                            ins_pc    <= pc;
                            state     <= HOLD;
                            ins_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid || ins_ready) begin
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        ins_valid <= 1'b0;
                        pc        <= redirect_valid ? redirect_addr : pc + WIDTH'(1);
                        if (ins_ready) begin
                            fetch_count <= fetch_count + COUNT_W'(1);
                        end
                    end
                end
                HALT: begin
                    if (redirect_valid || resume) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        halted   <= 1'b0;
                        pc       <= redirect_valid ? redirect_addr : pc + WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a behavioural instruction memory and a transfer
// scoreboard.
module tb_fetch_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = 16;

    logic               clk;
    logic               rst;
    logic               imem_req;
    logic [WIDTH-1:0]   imem_addr;
    logic               imem_rvalid;
    logic [31:0]        imem_rdata;
    logic               ins_valid;
    logic [31:0]        ins_data;
    logic [WIDTH-1:0]   ins_pc;
    logic               ins_ready;
    logic               redirect_valid;
    logic [WIDTH-1:0]   redirect_addr;
    logic               resume;
    logic               halted;
    logic [COUNT_W-1:0] fetch_count;

    fetch_sequencer #(
        .WIDTH      (WIDTH),
        .RESET_ADDR (32'h0),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .resume         (resume),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WIDTH-1:0] pc;
        logic [31:0]      data;
    } xfer_t;

    typedef struct {
        logic [WIDTH-1:0]   pc;
        logic [31:0]        data;
        int                 delay;
        int                 lat_next;
        logic [COUNT_W-1:0] exp_count;
    } vec_t;

    xfer_t exp_q[$];
    xfer_t got;
    vec_t  tbl[2];

    int               mem_lat = 1;
    bit               halt_en = 1'b0;
    logic [WIDTH-1:0] halt_addr = '0;

    function automatic logic [31:0] word(input logic [WIDTH-1:0] a);
        if (halt_en && a == halt_addr) return 32'h0000_007F;
        return {a[24:0], 7'h13};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!ins_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 64'(ins_valid), 64'd1);
    endtask

    task automatic wait_req(input string name, input logic [WIDTH-1:0] exp_addr, input bit forbid);
        int n = 0;
        bit seen = 1'b0;
        @(negedge clk);
        while (!imem_req && n < 20) begin
            seen |= ins_valid;
            @(negedge clk);
            n++;
        end
        check({name, "_req"}, 64'(imem_req), 64'd1);
        check({name, "_addr"}, 64'(imem_addr), 64'(exp_addr));
        if (forbid) check({name, "_novalid"}, 64'(seen), 64'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_req"},    64'(imem_req),    64'd0);
        check({name, "_valid"},  64'(ins_valid),   64'd0);
        check({name, "_halted"}, 64'(halted),      64'd0);
        check({name, "_data"},   64'(ins_data),    64'd0);
        check({name, "_pc"},     64'(ins_pc),      64'd0);
        check({name, "_count"},  64'(fetch_count), 64'd0);
        check({name, "_addr"},   64'(imem_addr),   64'd0);
    endtask

    // Instruction memory: one response per request after mem_lat cycles, flushed by rst.
    initial begin : mem_model
        logic [WIDTH-1:0] a;
        int  lat;
        bit  flushed;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (imem_req && !rst) begin
                a       = imem_addr;
                lat     = mem_lat;
                flushed = 1'b0;
                for (int i = 1; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) flushed = 1'b1;
                end
                @(posedge clk);
                #1;
                if (!flushed && !rst) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = word(a);
                    @(posedge clk);
                    #1;
                    imem_rvalid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_xfer", 64'(ins_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                check("sb_pc", 64'(ins_pc), 64'(got.pc));
                check("sb_data", 64'(ins_data), 64'(got.data));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit stable;
        bit seen;
        bit bad;
        int n;

        rst            = 1'b1;
        ins_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        resume         = 1'b0;

        tbl[0] = '{pc: 32'd3, data: 32'h0, delay: 4, lat_next: 1, exp_count: 16'd4};
        tbl[1] = '{pc: 32'd4, data: 32'h0, delay: 0, lat_next: 2, exp_count: 16'd5};
        for (int k = 0; k < 3; k++) exp_q.push_back('{pc: WIDTH'(k), data: word(WIDTH'(k))});
        for (int k = 0; k < 2; k++) begin
            tbl[k].data = word(tbl[k].pc);
            exp_q.push_back('{pc: tbl[k].pc, data: tbl[k].data});
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Best-case streaming: request every third cycle starting at cycle 1.
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("run_req", 64'(imem_req), 64'((c % 3) == 1));
            if ((c % 3) == 1) check("run_addr", 64'(imem_addr), 64'((c - 1) / 3));
            check("run_valid", 64'(ins_valid), 64'((c % 3) == 0));
        end
        @(posedge clk);
        @(negedge clk);
        check("run_count", 64'(fetch_count), 64'd3);
        check("run_addr3", 64'(imem_addr), 64'd3);
        @(posedge clk);
        #1;
        ins_ready = 1'b0;

        for (int k = 0; k < 2; k++) begin
            wait_valid("tbl");
            check("tbl_pc", 64'(ins_pc), 64'(tbl[k].pc));
            check("tbl_data", 64'(ins_data), 64'(tbl[k].data));
            stable = 1'b1;
            for (int i = 0; i < tbl[k].delay; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (!ins_valid || imem_req || ins_pc != tbl[k].pc || ins_data != tbl[k].data)
                    stable = 1'b0;
            end
            check("tbl_stall_stable", 64'(stable), 64'd1);
            @(posedge clk);
            #1;
            ins_ready = 1'b1;
            @(posedge clk);
            #1;
            ins_ready = 1'b0;
            mem_lat   = tbl[k].lat_next;
            @(negedge clk);
            check("tbl_next_req", 64'(imem_req), 64'd1);
            check("tbl_next_addr", 64'(imem_addr), 64'(tbl[k].pc + 1));
            check("tbl_count", 64'(fetch_count), 64'(tbl[k].exp_count));
        end

        // Redirect while waiting at pc=5, ahead of the (two-cycle) response.
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        mem_lat        = 1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_req("redir_wait", 32'h40, 1'b1);

        // Redirect coinciding with the response.
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h60;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_req("redir_rvalid", 32'h60, 1'b1);

        // Redirect coinciding with a transfer in HOLD.
        exp_q.push_back('{pc: 32'h60, data: word(32'h60)});
        wait_valid("hold_redir");
        check("hold_redir_pc", 64'(ins_pc), 64'h60);
        @(posedge clk);
        #1;
        ins_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80;
        @(posedge clk);
        #1;
        ins_ready      = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("hold_redir_req", 64'(imem_req), 64'd1);
        check("hold_redir_addr", 64'(imem_addr), 64'h80);
        check("hold_redir_count", 64'(fetch_count), 64'd6);
        check("hold_redir_novalid", 64'(ins_valid), 64'd0);

        // Redirect in HOLD without a transfer, to the halt instruction at pc=9.
        halt_en   = 1'b1;
        halt_addr = 32'd9;
        wait_valid("hold_only");
        check("hold_only_pc", 64'(ins_pc), 64'h80);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'd9;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("hold_only_novalid", 64'(ins_valid), 64'd0);
        check("hold_only_addr", 64'(imem_addr), 64'd9);
        check("hold_only_count", 64'(fetch_count), 64'd6);

        n    = 0;
        seen = 1'b0;
        while (!halted && n < 20) begin
            @(negedge clk);
            seen |= ins_valid;
            n++;
        end
        check("halt_enter", 64'(halted), 64'd1);
        check("halt_novalid", 64'(seen), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!halted || imem_req || ins_valid) bad = 1'b1;
        end
        check("halt_quiet", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        resume  = 1'b1;
        halt_en = 1'b0;
        @(posedge clk);
        #1;
        resume = 1'b0;
        @(negedge clk);
        check("resume_halted", 64'(halted), 64'd0);
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", 64'(imem_addr), 64'd10);

        // Reset in HOLD, with ready asserted in the same cycle.
        wait_valid("rst_hold");
        check("rst_hold_pc", 64'(ins_pc), 64'd10);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        ins_ready = 1'b1;
        mem_lat   = 2;
        @(posedge clk);
        #1;
        ins_ready = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_req("rst_hold_restart", 32'd0, 1'b1);

        // Reset in WAIT; the outstanding response is flushed with it.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("rst_wait");
        mem_lat = 1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Redirect in REQ to the last address, then check the PC wraps to 0.
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        exp_q.push_back('{pc: 32'hFFFF_FFFF, data: word(32'hFFFF_FFFF)});
        wait_req("wrap_req", 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        ins_ready = 1'b1;
        wait_req("wrap_next", 32'd0, 1'b0);
        check("wrap_count", 64'(fetch_count), 64'd1);
        @(posedge clk);
        #1;
        ins_ready = 1'b0;
        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
